// File: rtl/seq_sub64_pkg.sv
// ============================================================================
// Module  : seq_sub64_pkg
// Shared state encoding and slice-count helpers for the seq_sub64 subtractor.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_sub64_pkg;

   localparam int DEF_WIDTH  = 64;
   localparam int DEF_CHUNK  = 16;
   localparam int NUM_SLICES = DEF_WIDTH / DEF_CHUNK;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index register is never narrower than one bit, even for a single slice.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W = idx_width(NUM_SLICES);

endpackage

`default_nettype wire

// File: rtl/seq_sub64_sub_chunk.sv
// ============================================================================
// Module  : sub_chunk
// Combinational CHUNK-bit ripple-carry adder built from gate primitives.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sub_chunk #(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] nb,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   wire [CHUNK:0]   w_c;
   wire [CHUNK-1:0] w_p;
   wire [CHUNK-1:0] w_g;
   wire [CHUNK-1:0] w_pc;

   assign w_c[0] = cin;

   genvar i;
   generate
      for (i = 0; i < CHUNK; i++) begin : g_bit
         xor u_p  (w_p[i],   a[i],   nb[i]);
         and u_g  (w_g[i],   a[i],   nb[i]);
         xor u_s  (s[i],     w_p[i], w_c[i]);
         and u_pc (w_pc[i],  w_p[i], w_c[i]);
         or  u_c  (w_c[i+1], w_g[i], w_pc[i]);
      end
   endgenerate

   assign cout = w_c[CHUNK];

endmodule

`default_nettype wire

// File: rtl/seq_sub64.sv
// ============================================================================
// Module  : seq_sub64
// Multi-cycle A-B subtractor, one CHUNK slice per cycle, valid/ready in and out.
// Optional lt/ltu outputs enabled by SEQ_SUB64_SIGNED_CMP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_sub64
   import seq_sub64_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow,
   output logic             zero,
   output logic             negative
`ifdef SEQ_SUB64_SIGNED_CMP_EN
   ,
   output logic             lt,
   output logic             ltu
`endif
);

   localparam int N_SL     = WIDTH / CHUNK;
   localparam int SL_IDX_W = idx_width(N_SL);
   localparam logic [SL_IDX_W-1:0] LAST_IDX = SL_IDX_W'(N_SL - 1);

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_chunk
         $error("seq_sub64: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   state_t r_state, w_state_nxt;

   logic [N_SL-1:0][CHUNK-1:0] r_a;
   logic [N_SL-1:0][CHUNK-1:0] r_nb;
   logic [N_SL-1:0][CHUNK-1:0] r_diff;
   logic [N_SL-1:0][CHUNK-1:0] w_diff_nxt;
   logic [SL_IDX_W-1:0]        r_idx;
   logic                       r_carry;
   logic                       r_borrow, r_overflow, r_zero, r_negative;

   logic [CHUNK-1:0] w_a_s, w_nb_s, w_s;
   logic             w_cout;
   logic             w_last;

   assign w_a_s  = r_a[r_idx];
   assign w_nb_s = r_nb[r_idx];
   assign w_last = (r_idx == LAST_IDX);

   sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
      .a    (w_a_s),
      .nb   (w_nb_s),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_cout)
   );

   always_comb begin
      w_diff_nxt        = r_diff;
      w_diff_nxt[r_idx] = w_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid) w_state_nxt = RUN;
         end
         RUN: begin
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Flags are captured on the final slice so they hold through DONE without recomputation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a        <= '0;
         r_nb       <= '0;
         r_diff     <= '0;
         r_idx      <= '0;
         r_carry    <= 1'b0;
         r_borrow   <= 1'b0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b0;
         r_negative <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_nb    <= ~b;
                  r_carry <= 1'b1;
                  r_idx   <= '0;
               end
            end
            RUN: begin
               r_diff  <= w_diff_nxt;
               r_carry <= w_cout;
               r_idx   <= r_idx + 1'b1;
               if (w_last) begin
                  r_borrow   <= ~w_cout;
                  r_overflow <= (w_a_s[CHUNK-1] == w_nb_s[CHUNK-1]) &&
                                (w_s[CHUNK-1] != w_a_s[CHUNK-1]);
                  r_zero     <= (w_diff_nxt == '0);
                  r_negative <= w_s[CHUNK-1];
               end
            end
            default: ;
         endcase
      end
   end

   assign diff     = r_diff;
   assign borrow   = r_borrow;
   assign overflow = r_overflow;
   assign zero     = r_zero;
   assign negative = r_negative;

`ifdef SEQ_SUB64_SIGNED_CMP_EN
   logic r_lt, r_ltu;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lt  <= 1'b0;
         r_ltu <= 1'b0;
      end else if (r_state == RUN && w_last) begin
         r_lt  <= w_s[CHUNK-1] ^ ((w_a_s[CHUNK-1] == w_nb_s[CHUNK-1]) &&
                                  (w_s[CHUNK-1] != w_a_s[CHUNK-1]));
         r_ltu <= ~w_cout;
      end
   end

   assign lt  = r_lt;
   assign ltu = r_ltu;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_sub64.sv
// ============================================================================
// Module  : tb_seq_sub64
// Scoreboard bench for seq_sub64 with directed, hand-computed vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_sub64;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] diff;
   logic        borrow, overflow, zero, negative;
`ifdef SEQ_SUB64_SIGNED_CMP_EN
   logic        lt, ltu;
`endif

   always #5 clk = ~clk;

   seq_sub64 #(.WIDTH(64), .CHUNK(16)) dut (
`ifdef SEQ_SUB64_SIGNED_CMP_EN
      .lt        (lt),
      .ltu       (ltu),
`endif
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative)
   );

   typedef struct packed {
      logic [63:0] diff;
      logic        borrow;
      logic        overflow;
      logic        zero;
      logic        negative;
      logic        lt;
      logic        ltu;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] d, input logic bo, input logic ov,
                               input logic z, input logic n, input logic l, input logic lu);
      exp_t e;
      e.diff = d; e.borrow = bo; e.overflow = ov; e.zero = z; e.negative = n;
      e.lt = l; e.ltu = lu;
      return e;
   endfunction

   // Monitor: every result handshake must match the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got diff=%h expected no result", diff);
         end else begin
            e = sb.pop_front();
            check1("diff",     diff,     e.diff);
            check1("borrow",   64'(borrow),   64'(e.borrow));
            check1("overflow", 64'(overflow), 64'(e.overflow));
            check1("zero",     64'(zero),     64'(e.zero));
            check1("negative", 64'(negative), 64'(e.negative));
`ifdef SEQ_SUB64_SIGNED_CMP_EN
            check1("lt",       64'(lt),       64'(e.lt));
            check1("ltu",      64'(ltu),      64'(e.ltu));
`endif
         end
      end
   end

   task automatic send(input logic [63:0] av, input logic [63:0] bv, input exp_t e, input bit push);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check1("in_ready_before_send", 64'(in_ready), 64'd1);
      a = av; b = bv; in_valid = 1'b1;
      @(posedge clk);
      if (push) sb.push_back(e);
      #1;
      in_valid = 1'b0;
      a = ~av; b = av;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check1("drain_pending", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check1({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check1({tag, "_diff"},      diff,           64'd0);
      check1({tag, "_flags"},     64'({borrow, overflow, zero, negative}), 64'd0);
      check1({tag, "_in_ready"},  64'(in_ready),  64'd0);
`ifdef SEQ_SUB64_SIGNED_CMP_EN
      check1({tag, "_lt_ltu"},    64'({lt, ltu}), 64'd0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      #1;
      check1("in_ready_after_reset", 64'(in_ready), 64'd1);

      // Latency counted with the accept edge as cycle 1.
      send(64'd5, 64'd3, mk(64'd2, 0, 0, 0, 0, 0, 0), 1);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check1("latency", 64'(lat), 64'd5);
      wait_drain();

      send(64'd0, 64'd1, mk(64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 1, 1, 1), 1);
      wait_drain();
      send(64'h8000_0000_0000_0000, 64'd1, mk(64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 1, 0), 1);
      wait_drain();
      send(64'h1234, 64'h1234, mk(64'd0, 0, 0, 1, 0, 0, 0), 1);
      wait_drain();
      send(64'h0123_4567_89AB_CDEF, 64'h0000_0000_FFFF_FFFF,
           mk(64'h0123_4566_89AB_CDF0, 0, 0, 0, 0, 0, 0), 1);
      wait_drain();
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           mk(64'h8000_0000_0000_0000, 1, 1, 0, 1, 0, 1), 1);
      wait_drain();

      // Backpressure: result must hold and a new request must be ignored.
      out_ready = 1'b0;
      send(64'h10, 64'h20, mk(64'hFFFF_FFFF_FFFF_FFF0, 1, 0, 0, 1, 1, 1), 1);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      a = 64'd99; b = 64'd1; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check1("hold_out_valid", 64'(out_valid), 64'd1);
         check1("hold_diff",      diff,           64'hFFFF_FFFF_FFFF_FFF0);
         check1("hold_flags",     64'({borrow, overflow, zero, negative}), 64'b1001);
         check1("hold_in_ready",  64'(in_ready),  64'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      repeat (8) @(posedge clk);
      #1;
      check1("no_queued_op", 64'(out_valid), 64'd0);
      check1("idle_in_ready", 64'(in_ready), 64'd1);

      // Reset during the second RUN cycle discards the operation.
      send(64'd7, 64'd2, mk(64'd5, 0, 0, 0, 0, 0, 0), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_outputs_zero("mid_run_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      send(64'd3, 64'd5, mk(64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 1, 1, 1), 1);
      wait_drain();
      repeat (4) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
